// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the forward MixColumns stage: a 128-bit state in,
// a 128-bit mixed state out, each on its own valid/ready pair.
interface mix_columns_seq_if;
  logic [127:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  // Block side: consumes the input handshake, produces the output handshake.
  modport slave (
    input  data_in,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output data_out,
    output out_valid,
    output busy
  );

  // Upstream/downstream side, as seen by whoever drives the block.
  modport master (
    output data_in,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  data_out,
    input  out_valid,
    input  busy
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES-128 forward MixColumns. A state is latched on the input
// handshake, COLS_PER_CYCLE columns are mixed per clock, and the finished
// state is held on data_out until the output handshake completes. A new
// state may be accepted in the same cycle the previous result is taken.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  mix_columns_seq_if.slave  bus
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Column counter step and the counter value of the final BUSY cycle.
  // With four columns per cycle the step truncates to zero, which is the
  // intended wrap back to column 0.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] res_q, res_d;
  logic [1:0]   col_idx;
  logic         take_out;

  // GF(2^8) multiply by 2 with reduction by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // GF(2^8) multiply by 3 = 2x + x.
  function automatic logic [7:0] mul3(input logic [7:0] x);
    mul3 = xtime(x) ^ x;
  endfunction

  // One column through the MixColumns matrix; row 0 sits in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ mul3(a1) ^ a2        ^ a3;
    b1 = a0        ^ xtime(a1) ^ mul3(a2) ^ a3;
    b2 = a0        ^ a1        ^ xtime(a2) ^ mul3(a3);
    b3 = mul3(a0)  ^ a1        ^ a2        ^ xtime(a3);
    mix_col = {b0, b1, b2, b3};
  endfunction

  assign take_out = (state_q == DONE) && bus.out_ready;

  // Next-state logic: input acceptance, per-cycle column mixing, output release.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    blk_d     = blk_q;
    res_d     = res_q;
    col_idx   = 2'd0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          blk_d     = bus.data_in;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          col_idx = col_cnt_q + 2'(k);
          res_d[{col_idx, 5'd0} +: 32] = mix_col(blk_q[{col_idx, 5'd0} +: 32]);
        end
        col_cnt_d = col_cnt_q + STEP;
        if (col_cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Result stays frozen here; a fresh block can ride in on the same
        // cycle the downstream takes the current one.
        if (take_out) begin
          if (bus.in_valid) begin
            blk_d     = bus.data_in;
            col_cnt_d = 2'd0;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, captured input and result registers; reset clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      blk_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      blk_q     <= blk_d;
      res_q     <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) || take_out;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.data_out  = res_q;

endmodule
